mem_dados_resposta: RTL and testbench
=====================================

# mem_dados_resposta

Data-memory responder for the nRisc core: the slave end of the processor's LerMem/EscreveMem data-memory interface. It holds a 256 x 8 data store, accepts one read or write request at a time, inserts a configurable number of wait states, and signals completion with a one-cycle `pronto` pulse. It sits between the nRisc data port (`endereco`, `dado`, `LerMem`, `EscreveMem`) and the processor's load path, replacing a zero-latency memory so slow-memory stalls can be modelled.

## Interface
- `LATENCIA`, default 2: wait states inserted before each access commits. Legal range is 0..15, held in a 4-bit counter.
- `clock` input 1: single clock. All state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `endereco` input 8: byte address of the request.
- `dado` input 8: write data. Sampled together with `endereco`.
- `LerMem` input 1: read request. Level signal, held by the initiator until the handshake finishes.
- `EscreveMem` input 1: write request. Level signal, same rules as `LerMem`.
- `out` output 8: read data. Registered, and holds its value between reads.
- `pronto` output 1: one-cycle completion pulse.
- `erro` output 1: one-cycle pulse for an illegal request (both strobes high).
- `ocupado` output 1: high whenever the FSM is not in IDLE.

## Operation
- Storage: 256 x 8 registers. Reset clears every location to 0.
- States:
  - IDLE: waits for a request.
  - ESPERA: counts down wait states.
  - FIM: waits for the initiator to drop its request.
- IDLE:
  - Exactly one of `LerMem`/`EscreveMem` high at an edge: latch `endereco`, `dado` and the operation type; load the counter with `LATENCIA`; go to ESPERA.
  - Both high: pulse `erro`, perform no access, go to FIM.
  - Neither high: stay in IDLE.
- ESPERA:
  - Counter not zero: decrement it and stay.
  - Counter zero, write: at this edge (commit edge), store the latched data at the latched address.
  - Counter zero, read: at the commit edge, load `out` from the latched address.
  - Either case: set `pronto`, go to FIM.
- FIM:
  - `pronto` and `erro` clear after one cycle.
  - Stay until both strobes are low, then go to IDLE. This guarantees exactly one access per handshake, even if the initiator holds its strobe for extra cycles.
- Strobe or input changes while in ESPERA are ignored; the values latched in IDLE are used.
- Write-then-read at the same address in back-to-back handshakes returns the new data.
- `out` is not affected by writes and only changes at a read commit edge.

## Timing
- Reset values: state IDLE, `out`=0, `pronto`=0, `erro`=0, `ocupado`=0, counter=0, all memory locations 0.
- Latency:
  - Request first seen at edge k gives commit at edge k+1+LATENCIA.
  - `pronto` is high for exactly the cycle after the commit edge.
  - `LATENCIA`=0: commit at edge k+1.
- `ocupado` rises the cycle after acceptance and falls the cycle after both strobes are seen low in FIM.
- Minimum handshake period: LATENCIA+3 cycles (IDLE accept, ESPERA x (LATENCIA+1), FIM with strobes already low).
- Reset asserted mid-transaction:
  - Returns immediately to IDLE with the reset values above.
  - A write that has not reached its commit edge never occurs; memory is cleared anyway.
- Reset released with a strobe high: the request is accepted at the first edge after release.

## Test plan
- Write, LATENCIA=2: assert EscreveMem with endereco=0x05, dado=0xA7 at edge 0. Required: `pronto` high only in the cycle after edge 3, `ocupado` high from edge 1. A later read of 0x05 returns 0xA7.
- Read timing, LATENCIA=0: after the write above, assert LerMem with endereco=0x05. Required: `out`=0xA7 and `pronto`=1 in the cycle after edge 1. `out` stays 0xA7 after LerMem drops.
- Held strobe: hold EscreveMem=1, endereco=0x10, dado=0x01 for 10 cycles, then change dado to 0x02 still in FIM. Required: one `pronto` pulse only, and memory[0x10]=0x01.
- Illegal request: assert LerMem=EscreveMem=1. Required: `erro` pulses once, `pronto` stays 0, no memory location changes, `out` is unchanged.
- Reset mid-write: start a write of 0xFF to 0x20 with LATENCIA=5, then pull `reset_n` low at edge 3. Required: immediately `ocupado`=0, `out`=0, FSM in IDLE. After release, reading 0x20 returns 0x00.
- Back-to-back: write 0x3C to 0x00, drop the strobe, read 0x00 on the following cycle. Required: read returns 0x3C, and total elapsed time is 2x(LATENCIA+3) cycles.

Source files
------------

// File: rtl/mem_dados_resposta_if.sv
// Data-memory request bus between the nRisc data port (master) and the memory responder (slave).
// Handshake: the master raises exactly one of LerMem/EscreveMem with endereco/dado stable and holds it;
// the slave answers with a one-cycle pronto (or erro if both strobes are high), and a new request is
// accepted only after the master has dropped both strobes while the slave is in its end state.
interface mem_dados_resposta_if;
  logic [7:0] endereco;
  logic [7:0] dado;
  logic       LerMem;
  logic       EscreveMem;
  logic [7:0] out;
  logic       pronto;
  logic       erro;
  logic       ocupado;

  modport master (
    output endereco, dado, LerMem, EscreveMem,
    input  out, pronto, erro, ocupado
  );

  modport slave (
    input  endereco, dado, LerMem, EscreveMem,
    output out, pronto, erro, ocupado
  );
endinterface

// File: rtl/mem_dados_resposta.sv
// 256 x 8 data memory responder with LATENCIA wait states per access and a pronto/erro pulse handshake.
// estado exposes the FSM state (0 IDLE, 1 ESPERA, 2 FIM).
module mem_dados_resposta #(
  parameter int LATENCIA = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mem_dados_resposta_if.slave  bus,
  output logic [1:0]           estado
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    FIM    = 2'd2
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCIA);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic [7:0] end_q;
  logic [7:0] dado_q;
  logic       escrita_q;
  logic [7:0] mem [256];
  logic [7:0] out_q;
  logic       pronto_q;
  logic       erro_q;

  logic req_one, req_both, strobes_low;
  logic aceita, ilegal, commit;

  assign req_one     = bus.LerMem ^ bus.EscreveMem;
  assign req_both    = bus.LerMem & bus.EscreveMem;
  assign strobes_low = ~(bus.LerMem | bus.EscreveMem);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_both)     state_next = FIM;
        else if (req_one) state_next = ESPERA;
      end
      ESPERA: if (cnt == 4'd0) state_next = FIM;
      FIM:    if (strobes_low) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    aceita      = 1'b0;
    ilegal      = 1'b0;
    commit      = 1'b0;
    bus.ocupado = (state != IDLE);
    case (state)
      IDLE: begin
        aceita = req_one;
        ilegal = req_both;
      end
      ESPERA: commit = (cnt == 4'd0);
      default: ;
    endcase
  end

  // Request latch, wait counter and the registered response outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 4'd0;
      end_q     <= 8'd0;
      dado_q    <= 8'd0;
      escrita_q <= 1'b0;
      out_q     <= 8'd0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      pronto_q <= commit;
      erro_q   <= ilegal;
      if (aceita) begin
        cnt       <= LAT4;
        end_q     <= bus.endereco;
        dado_q    <= bus.dado;
        escrita_q <= bus.EscreveMem;
      end else if (state == ESPERA && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !escrita_q) out_q <= mem[end_q];
    end
  end

  // Storage; reset wipes every location, including any write not yet committed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
    end else if (commit && escrita_q) begin
      mem[end_q] <= dado_q;
    end
  end

  assign bus.out    = out_q;
  assign bus.pronto = pronto_q;
  assign bus.erro   = erro_q;
  assign estado     = state;

endmodule

// File: tb/tb_mem_dados_resposta.sv
// Directed and randomized handshakes against a cycle-indexed reference model of the data memory responder.
module tb_mem_dados_resposta;
  localparam int LAT = 2;

  logic       clock;
  logic       reset_n;
  logic [1:0] estado;

  mem_dados_resposta_if bus ();

  mem_dados_resposta #(.LATENCIA(LAT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .estado  (estado)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem_model [256];
  logic [7:0] out_model;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem_model[i] = 8'd0;
    out_model = 8'd0;
  endtask

  // op: 0 read, 1 write, 2 both strobes (illegal). Strobes are high for edges 0..hold-1.
  task automatic handshake(input int op, input logic [7:0] addr, input logic [7:0] data,
                           input int hold, input string tag);
    int         e_end;
    bit         legal;
    logic [7:0] exp_out;
    legal = (op != 2);
    if (legal) e_end = (hold > LAT + 2) ? hold : LAT + 2;
    else       e_end = (hold > 1) ? hold : 1;
    bus.endereco   = addr;
    bus.dado       = data;
    bus.LerMem     = (op == 0 || op == 2);
    bus.EscreveMem = (op == 1 || op == 2);
    for (int e = 0; e <= e_end; e++) begin
      @(posedge clock);
      @(negedge clock);
      exp_out = (op == 0 && e >= LAT + 1) ? mem_model[addr] : out_model;
      chk({tag, ".pronto"},  8'(bus.pronto),  8'(legal && e == LAT + 1));
      chk({tag, ".erro"},    8'(bus.erro),    8'(!legal && e == 0));
      chk({tag, ".ocupado"}, 8'(bus.ocupado), 8'(e < e_end));
      chk({tag, ".out"},     bus.out,         exp_out);
      // Address/data wander after acceptance; the latched request must be the one used
      bus.endereco = 8'($urandom);
      bus.dado     = 8'($urandom);
      if (e + 1 >= hold) begin
        bus.LerMem     = 1'b0;
        bus.EscreveMem = 1'b0;
      end
    end
    chk({tag, ".estado_idle"}, 8'(estado), 8'd0);
    if (op == 1) mem_model[addr] = data;
    if (op == 0) out_model = mem_model[addr];
  endtask

  initial begin
    int op, hold;
    logic [7:0] a, d;
    bus.endereco   = 8'd0;
    bus.dado       = 8'd0;
    bus.LerMem     = 1'b0;
    bus.EscreveMem = 1'b0;
    reset_n        = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst.out",     bus.out,         8'd0);
    chk("rst.pronto",  8'(bus.pronto),  8'd0);
    chk("rst.erro",    8'(bus.erro),    8'd0);
    chk("rst.ocupado", 8'(bus.ocupado), 8'd0);
    chk("rst.estado",  8'(estado),      8'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Write 0xA7 to 0x05, then read it back with minimal handshakes
    handshake(1, 8'h05, 8'hA7, LAT + 2, "wr05");
    handshake(0, 8'h05, 8'h00, LAT + 2, "rd05");
    @(negedge clock);
    chk("rd05.out_hold", bus.out, 8'hA7);

    // Held strobe: one access only, with dado changing while in FIM
    handshake(1, 8'h10, 8'h01, 10, "held");
    handshake(0, 8'h10, 8'h00, 1, "held_rd");

    // Illegal request: erro only, nothing stored, out unchanged
    handshake(2, 8'h05, 8'h55, 1, "ilg");
    handshake(2, 8'h05, 8'h66, 4, "ilg_hold");
    handshake(0, 8'h05, 8'h00, LAT + 2, "ilg_rd");

    // Back-to-back write then read at address 0
    handshake(1, 8'h00, 8'h3C, LAT + 2, "b2b_wr");
    handshake(0, 8'h00, 8'h00, LAT + 2, "b2b_rd");
    chk("b2b.value", bus.out, 8'h3C);

    // Reset before the commit edge of a write
    bus.endereco   = 8'h20;
    bus.dado       = 8'hFF;
    bus.EscreveMem = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst.ocupado", 8'(bus.ocupado), 8'd0);
    chk("mid_rst.out",     bus.out,         8'd0);
    chk("mid_rst.estado",  8'(estado),      8'd0);
    chk("mid_rst.pronto",  8'(bus.pronto),  8'd0);
    bus.EscreveMem = 1'b0;
    bus.endereco   = 8'h20;
    bus.LerMem     = 1'b1;
    @(negedge clock);
    // Released with the read strobe already high: accepted at the first edge
    reset_n = 1'b1;
    handshake(0, 8'h20, 8'h00, LAT + 2, "rst_rd20");
    handshake(0, 8'h10, 8'h00, 1, "rst_rd10");

    // Randomized traffic over a small address window so writes and reads collide
    for (int n = 0; n < 60; n++) begin
      op   = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      a    = 8'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 8'hF8 : 8'h00);
      d    = 8'($urandom);
      hold = int'($urandom_range(1, LAT + 5));
      if (op == 1) exp_q.push_back(d);
      handshake(op, a, d, hold, "rnd");
    end
    // Every written value must have reached the store and still be readable where not overwritten
    for (int i = 0; i < 8; i++) begin
      handshake(0, 8'(i), 8'h00, LAT + 2, "sweep");
      handshake(0, 8'hF8 | 8'(i), 8'h00, 1, "sweep_hi");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on total simulation time
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
